// File: rtl/mult32x32_pkg.sv
// Shared types and constants for the 32x32 multiplier controller and arithmetic unit.
package mult32x32_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LL   = 3'd1,
        LH   = 3'd2,
        HL   = 3'd3,
        HH   = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [1:0] SHIFT_0    = 2'b00;
    localparam logic [1:0] SHIFT_16   = 2'b01;
    localparam logic [1:0] SHIFT_32   = 2'b10;
    localparam logic [1:0] SHIFT_ZERO = 2'b11;

    localparam logic SEL_HI = 1'b0;
    localparam logic SEL_LO = 1'b1;

endpackage

// File: rtl/mult32x32_ctrl_if.sv
// Requester/arithmetic-side bundle of the multiplier controller; state_dbg mirrors the FSM state.
interface mult32x32_ctrl_if;
    import mult32x32_pkg::*;

    // Handshake: a request is accepted on a rising clk edge where start && ready;
    // start is ignored otherwise (no queuing). done pulses for one cycle per accepted request.
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] a;
    logic [31:0] b;
    logic        a_sel;
    logic        b_sel;
    logic [1:0]  shift_sel;
    logic        upd_prod;
    logic        clr_prod;
    state_t      state_dbg;

    modport master (
        output start, a_in, b_in,
        input  ready, busy, done, a, b, a_sel, b_sel, shift_sel, upd_prod, clr_prod, state_dbg
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, busy, done, a, b, a_sel, b_sel, shift_sel, upd_prod, clr_prod, state_dbg
    );

endinterface

// File: rtl/mult32x32_ctrl_next.sv
// Combinational next-state logic; MULT32X32_SKIP_ZERO_EN enables skipping zero partial products.
module mult32x32_ctrl_next
    import mult32x32_pkg::*;
(
    input  state_t      state,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output state_t      next_state
);

`ifdef MULT32X32_SKIP_ZERO_EN
    // A partial product is worth a cycle only when both selected halves are non-zero.
    logic ll_en, lh_en, hl_en, hh_en;

    assign ll_en = (|op_a[15:0])  && (|op_b[15:0]);
    assign lh_en = (|op_a[15:0])  && (|op_b[31:16]);
    assign hl_en = (|op_a[31:16]) && (|op_b[15:0]);
    assign hh_en = (|op_a[31:16]) && (|op_b[31:16]);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) begin
                if      (ll_en) next_state = LL;
                else if (lh_en) next_state = LH;
                else if (hl_en) next_state = HL;
                else if (hh_en) next_state = HH;
                else            next_state = DONE;
            end
            LL: begin
                if      (lh_en) next_state = LH;
                else if (hl_en) next_state = HL;
                else if (hh_en) next_state = HH;
                else            next_state = DONE;
            end
            LH: begin
                if      (hl_en) next_state = HL;
                else if (hh_en) next_state = HH;
                else            next_state = DONE;
            end
            HL:      next_state = hh_en ? HH : DONE;
            HH:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
`else
    logic unused_ops;
    assign unused_ops = ^{op_a, op_b};

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LL;
            LL:      next_state = LH;
            LH:      next_state = HL;
            HL:      next_state = HH;
            HH:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
`endif

endmodule

// File: rtl/mult32x32_ctrl.sv
// Sequencing FSM for the 32x32 multiplier: four 16x16 partial products, then a done pulse.
// Optional build macro: MULT32X32_SKIP_ZERO_EN (skip partial products with a zero half).
module mult32x32_ctrl
    import mult32x32_pkg::*;
#(
    parameter bit CAPTURE_OPERANDS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    mult32x32_ctrl_if.slave   bus
);

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign accept = (state == IDLE) && bus.start;

    // The skip decision must see the incoming operands on the accept edge.
    assign op_a = (state == IDLE) ? bus.a_in : bus.a;
    assign op_b = (state == IDLE) ? bus.b_in : bus.b;

    mult32x32_ctrl_next u_next (
        .state      (state),
        .start      (bus.start),
        .op_a       (op_a),
        .op_b       (op_b),
        .next_state (next_state)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    generate
        if (CAPTURE_OPERANDS) begin : g_capture
            logic [31:0] a_q;
            logic [31:0] b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (accept) begin
                    a_q <= bus.a_in;
                    b_q <= bus.b_in;
                end
            end

            assign bus.a = a_q;
            assign bus.b = b_q;
        end else begin : g_passthru
            assign bus.a = bus.a_in;
            assign bus.b = bus.b_in;
        end
    endgenerate

    always_comb begin
        bus.a_sel     = SEL_HI;
        bus.b_sel     = SEL_HI;
        bus.shift_sel = SHIFT_ZERO;
        bus.upd_prod  = 1'b0;
        case (state)
            LL: begin
                bus.a_sel     = SEL_LO;
                bus.b_sel     = SEL_LO;
                bus.shift_sel = SHIFT_0;
                bus.upd_prod  = 1'b1;
            end
            LH: begin
                bus.a_sel     = SEL_LO;
                bus.b_sel     = SEL_HI;
                bus.shift_sel = SHIFT_16;
                bus.upd_prod  = 1'b1;
            end
            HL: begin
                bus.a_sel     = SEL_HI;
                bus.b_sel     = SEL_LO;
                bus.shift_sel = SHIFT_16;
                bus.upd_prod  = 1'b1;
            end
            HH: begin
                bus.a_sel     = SEL_HI;
                bus.b_sel     = SEL_HI;
                bus.shift_sel = SHIFT_32;
                bus.upd_prod  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ready     = (state == IDLE);
    assign bus.busy      = (state == LL) || (state == LH) || (state == HL) || (state == HH);
    assign bus.done      = (state == DONE);
    assign bus.clr_prod  = accept;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Directed + random bench for mult32x32_ctrl with a behavioural product-register model.
module tb_mult32x32_ctrl;

    logic        clk;
    logic        reset;
    int          errors;
    int          checks;
    logic [63:0] prod;

    mult32x32_ctrl_if bus();

    mult32x32_ctrl #(.CAPTURE_OPERANDS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- arithmetic unit model ----------------
    function automatic logic [63:0] partial(input logic as, input logic bs, input logic [1:0] sh,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ha;
        logic [63:0] hb;
        logic [63:0] m;
        ha = {48'd0, (as ? a[15:0] : a[31:16])};
        hb = {48'd0, (bs ? b[15:0] : b[31:16])};
        m  = ha * hb;
        case (sh)
            2'b00:   return m;
            2'b01:   return m << 16;
            2'b10:   return m << 32;
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset)             prod <= 64'd0;
        else if (bus.clr_prod) prod <= 64'd0;
        else if (bus.upd_prod) prod <= prod + partial(bus.a_sel, bus.b_sel, bus.shift_sel, bus.a, bus.b);
    end

    // Number of partial-product cycles the controller should spend on a*b.
    function automatic int n_parts(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT32X32_SKIP_ZERO_EN
        int n;
        n = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if ((a >> (16 * i)) & 32'hFFFF && (b >> (16 * j)) & 32'hFFFF) n++;
        return n;
`else
        return (a == b) ? 4 : 4;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_mult(input logic [31:0] ta, input logic [31:0] tb_op, input bit corrupt,
                            input string tag, output int lat);
        int exp_lat;
        int n_upd;
        bit seen;
        logic [63:0] exp_prod;
        exp_prod = {32'd0, ta} * {32'd0, tb_op};
        exp_lat  = 1 + n_parts(ta, tb_op);
        n_upd    = 0;
        seen     = 1'b0;
        lat      = 0;
        @(negedge clk);
        bus.a_in  = ta;
        bus.b_in  = tb_op;
        bus.start = 1'b1;
        #1;
        check({tag, "_ready"}, {63'd0, bus.ready}, 64'd1);
        check({tag, "_clr"}, {63'd0, bus.clr_prod}, 64'd1);
        @(posedge clk);
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                if (corrupt) begin
                    bus.a_in = 32'hDEADBEEF;
                    bus.b_in = 32'h12345678;
                end
            end
            if (bus.upd_prod) n_upd++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_upd_cycles"}, 64'(n_upd), 64'(exp_lat - 1));
        check({tag, "_product"}, prod, exp_prod);
        @(negedge clk);
        check({tag, "_done_pulse"}, {62'd0, bus.done, bus.ready}, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int acc_n, done_n, exp_acc, exp_done, last_acc, gap_bad;
        int per, lat3;
        logic [31:0] ra, rb;
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", {63'd0, bus.ready}, 64'd1);
        check("rst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("rst_ab", {bus.a, bus.b}, 64'd0);
        check("rst_upd_clr", {62'd0, bus.upd_prod, bus.clr_prod}, 64'd0);

        // Plan 1 and 2
        run_mult(32'h3, 32'h5, 1'b0, "small", lat);
        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "max", lat);
        check("max_const", prod, 64'hFFFFFFFE00000001);

        // Plan 3: start held for 12 cycles
        lat3     = 1 + n_parts(32'h00012345, 32'h10);
        per      = lat3 + 1;
        exp_acc  = 0;
        exp_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (k % per == 0) exp_acc++;
            if (k % per == lat3) exp_done++;
        end
        acc_n    = 0;
        done_n   = 0;
        last_acc = -1;
        gap_bad  = 0;
        @(negedge clk);
        bus.a_in  = 32'h00012345;
        bus.b_in  = 32'h00000010;
        bus.start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (bus.ready && bus.start) begin
                if (last_acc >= 0 && (k - last_acc) != per) gap_bad++;
                last_acc = k;
                acc_n++;
            end
            if (bus.ready && bus.busy) gap_bad++;
            if (bus.done) begin
                done_n++;
                check("held_product", prod, 64'h0000000000123450);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("held_accepts", 64'(acc_n), 64'(exp_acc));
        check("held_dones", 64'(done_n), 64'(exp_done));
        check("held_gap", 64'(gap_bad), 64'd0);
        repeat (per) @(negedge clk);

        // Plan 4: operand change after accept
        run_mult(32'h00000007, 32'h00090011, 1'b1, "capture", lat);

        // Plan 5: reset mid-operation (all halves non-zero so HL is reached in every build)
        @(negedge clk);
        bus.a_in  = 32'h00030002;
        bus.b_in  = 32'h00050004;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("ll_ctrl", {59'd0, bus.a_sel, bus.b_sel, bus.shift_sel, bus.upd_prod}, 64'b11001);
        @(negedge clk);
        check("lh_ctrl", {59'd0, bus.a_sel, bus.b_sel, bus.shift_sel, bus.upd_prod}, 64'b10011);
        @(negedge clk);
        check("hl_ctrl", {59'd0, bus.a_sel, bus.b_sel, bus.shift_sel, bus.upd_prod}, 64'b01011);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready_busy", {62'd0, bus.ready, bus.busy}, 64'b10);
        check("abort_ab", {bus.a, bus.b}, 64'd0);
        done_n = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.done) done_n++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_n), 64'd0);
        run_mult(32'd2, 32'd3, 1'b0, "post_reset", lat);
        check("post_reset_six", prod, 64'd6);

`ifdef MULT32X32_SKIP_ZERO_EN
        // Plan 6
        run_mult(32'h00010000, 32'h2, 1'b0, "skip_hl", lat);
        check("skip_hl_lat", 64'(lat), 64'd2);
        check("skip_hl_prod", prod, 64'h20000);
        run_mult(32'd0, 32'h1234, 1'b0, "skip_zero", lat);
        check("skip_zero_lat", 64'(lat), 64'd1);
`endif

        // Random operands, with halves randomly zeroed to hit the skip paths
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra[15:0]  = 16'd0;
            if ($urandom_range(0, 3) == 0) ra[31:16] = 16'd0;
            if ($urandom_range(0, 3) == 0) rb[15:0]  = 16'd0;
            if ($urandom_range(0, 3) == 0) rb[31:16] = 16'd0;
            run_mult(ra, rb, $urandom_range(0, 1) == 1, "rand", lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
